// File: rtl/ram256_access_ctrl.sv
// ram256_access_ctrl: host req/ack front end sequencing select-stable -> strobe -> hold writes into four 64x8 banks
module ram256_access_ctrl #(
  parameter int DATA_W   = 8,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [7:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              wr_enable,
  output logic [1:0]        bank_sel,
  output logic [5:0]        bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata0,
  input  logic [DATA_W-1:0] bank_rdata1,
  input  logic [DATA_W-1:0] bank_rdata2,
  input  logic [DATA_W-1:0] bank_rdata3
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, READ, DONE} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic we_q;
  logic [DATA_W-1:0] mux_rdata;
  if (WR_PULSE < 1 || WR_PULSE > 15) begin : g_bad_pulse
    $error("WR_PULSE must be within 1..15");
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= state == SETUP ? 4'(WR_PULSE - 1) : (state == STROBE && cnt != 0) ? cnt - 4'd1 : cnt;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req ? SETUP : IDLE;
      SETUP:   nxt = we_q ? STROBE : READ;
      STROBE:  nxt = cnt == 0 ? HOLD : STROBE;
      HOLD:    nxt = DONE;
      READ:    nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    ack  = state == DONE;
    busy = state != IDLE;
  end
  assign mux_rdata = bank_sel == 2'd0 ? bank_rdata0 :
                     bank_sel == 2'd1 ? bank_rdata1 :
                     bank_sel == 2'd2 ? bank_rdata2 : bank_rdata3;
  // bank address/data/select only move on acceptance, so the demux select never changes around the strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q       <= 1'b0;
      bank_sel   <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      wr_enable  <= 1'b0;
      rdata      <= '0;
    end else begin
      if (state == IDLE && req) begin
        we_q       <= we;
        bank_sel   <= addr[7:6];
        bank_addr  <= addr[5:0];
        bank_wdata <= wdata;
      end
      wr_enable <= nxt == STROBE;
      if (state == READ) rdata <= mux_rdata;
    end
endmodule
